// File: rtl/mg2_arbiter.sv
// Two-input round-robin merge arbiter for 4-phase Send/Ack channels.
// Latches the winner's data and CPY/EXB mode, counts transfers, and flags a REQ-state timeout.
module mg2_arbiter #(
  parameter int W    = 16,
  parameter int CNTW = 8,
  parameter int TMO  = 255
) (
  input  logic            CLK,
  input  logic            MR,
  input  logic            Send_in0,
  input  logic            Send_in1,
  input  logic [W-1:0]    Data_in0,
  input  logic [W-1:0]    Data_in1,
  output logic            Ack_out0,
  output logic            Ack_out1,
  input  logic [1:0]      EN,
  input  logic [1:0]      CFG_CPY,
  input  logic [1:0]      CFG_EXB,
  output logic            Send_out,
  input  logic            Ack_in,
  output logic [W-1:0]    Data_out,
  output logic            CPY,
  output logic            EXB,
  output logic            GNT,
  output logic            BUSY,
  output logic [CNTW-1:0] CNT0,
  output logic [CNTW-1:0] CNT1,
  output logic            ERR
);

  typedef enum logic [1:0] {IDLE, REQ, ACKUP} state_t;

  state_t      state;
  logic        pri;
  logic [15:0] wdog;
  logic [15:0] wdog_nxt;
  logic [1:0]  elig;
  logic        pick;
  logic        gnt_send;

  assign elig     = {Send_in1, Send_in0} & EN;
  assign gnt_send = GNT ? Send_in1 : Send_in0;
  // Watchdog saturates so a very long stall cannot wrap back below TMO.
  assign wdog_nxt = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;

  always_comb begin
    pick = elig[1];
    if (elig == 2'b11) pick = pri;
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state    <= IDLE;
      pri      <= 1'b0;
      wdog     <= '0;
      Send_out <= 1'b0;
      Ack_out0 <= 1'b0;
      Ack_out1 <= 1'b0;
      Data_out <= '0;
      CPY      <= 1'b0;
      EXB      <= 1'b1;
      GNT      <= 1'b0;
      BUSY     <= 1'b0;
      CNT0     <= '0;
      CNT1     <= '0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (elig != 2'b00) begin
            GNT      <= pick;
            Data_out <= pick ? Data_in1 : Data_in0;
            CPY      <= CFG_CPY[pick];
            EXB      <= CFG_EXB[pick];
            Send_out <= 1'b1;
            BUSY     <= 1'b1;
            wdog     <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          wdog <= wdog_nxt;
          if (wdog_nxt == 16'(TMO)) ERR <= 1'b1;
          // A requester dropping Send here is a protocol violation and is ignored.
          if (Ack_in) begin
            Send_out <= 1'b0;
            if (GNT) Ack_out1 <= 1'b1;
            else     Ack_out0 <= 1'b1;
            state <= ACKUP;
          end
        end
        ACKUP: begin
          if (!Ack_in && !gnt_send) begin
            if (GNT) begin
              Ack_out1 <= 1'b0;
              CNT1     <= CNT1 + CNTW'(1);
            end else begin
              Ack_out0 <= 1'b0;
              CNT0     <= CNT0 + CNTW'(1);
            end
            pri   <= ~GNT;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mg2_arbiter.sv
// Directed bench for mg2_arbiter: vector table for reset/single/alternating grants,
// hand sequences for masking, counter wrap, timeout and mid-transfer reset.
module tb_mg2_arbiter;

  logic        CLK = 1'b0;
  logic        MR;
  logic        Send_in0, Send_in1;
  logic [15:0] Data_in0, Data_in1;
  logic        Ack_out0, Ack_out1;
  logic [1:0]  EN, CFG_CPY, CFG_EXB;
  logic        Send_out, Ack_in;
  logic [15:0] Data_out;
  logic        CPY, EXB, GNT, BUSY, ERR;
  logic [1:0]  CNT0, CNT1;

  int n_cmp = 0;
  int n_bad = 0;

  mg2_arbiter #(.W(16), .CNTW(2), .TMO(4)) dut (
    .CLK(CLK), .MR(MR),
    .Send_in0(Send_in0), .Send_in1(Send_in1),
    .Data_in0(Data_in0), .Data_in1(Data_in1),
    .Ack_out0(Ack_out0), .Ack_out1(Ack_out1),
    .EN(EN), .CFG_CPY(CFG_CPY), .CFG_EXB(CFG_EXB),
    .Send_out(Send_out), .Ack_in(Ack_in),
    .Data_out(Data_out), .CPY(CPY), .EXB(EXB), .GNT(GNT),
    .BUSY(BUSY), .CNT0(CNT0), .CNT1(CNT1), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        mr, s0, s1, ack;
    logic [15:0] d0, d1;
    logic        so, a0, a1;
    logic [15:0] dout;
    logic        gnt, cpy, exb, busy;
    logic [1:0]  c0, c1;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic mr, logic s0, logic s1, logic ack,
                              logic [15:0] d0, logic [15:0] d1,
                              logic so, logic a0, logic a1, logic [15:0] dout,
                              logic gnt, logic cpy, logic exb, logic busy,
                              logic [1:0] c0, logic [1:0] c1, logic err);
    vec_t v;
    v.mr = mr; v.s0 = s0; v.s1 = s1; v.ack = ack; v.d0 = d0; v.d1 = d1;
    v.so = so; v.a0 = a0; v.a1 = a1; v.dout = dout; v.gnt = gnt;
    v.cpy = cpy; v.exb = exb; v.busy = busy; v.c0 = c0; v.c1 = c1; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".send_out"}, 32'(Send_out), 0);
    chk({tag, ".ack0"},     32'(Ack_out0), 0);
    chk({tag, ".ack1"},     32'(Ack_out1), 0);
    chk({tag, ".data"},     32'(Data_out), 0);
    chk({tag, ".cpy"},      32'(CPY), 0);
    chk({tag, ".exb"},      32'(EXB), 1);
    chk({tag, ".gnt"},      32'(GNT), 0);
    chk({tag, ".busy"},     32'(BUSY), 0);
    chk({tag, ".cnt0"},     32'(CNT0), 0);
    chk({tag, ".cnt1"},     32'(CNT1), 0);
    chk({tag, ".err"},      32'(ERR), 0);
  endtask

  // Full minimum-length transfer on input 1 with the other input idle.
  task automatic xfer1(input logic [15:0] d, input logic [1:0] exp_cnt);
    Send_in1 = 1'b1; Data_in1 = d;
    step();
    chk("x1.grant_so", 32'(Send_out), 1);
    chk("x1.grant_gnt", 32'(GNT), 1);
    chk("x1.grant_data", 32'(Data_out), 32'(d));
    Ack_in = 1'b1;
    step();
    chk("x1.ack1", 32'(Ack_out1), 1);
    chk("x1.so_low", 32'(Send_out), 0);
    Ack_in = 1'b0; Send_in1 = 1'b0;
    step();
    chk("x1.rel_ack1", 32'(Ack_out1), 0);
    chk("x1.rel_busy", 32'(BUSY), 0);
    chk("x1.cnt1", 32'(CNT1), 32'(exp_cnt));
  endtask

  initial begin
    MR = 1'b1; Send_in0 = 0; Send_in1 = 0; Data_in0 = 0; Data_in1 = 0;
    EN = 2'b11; CFG_CPY = 2'b01; CFG_EXB = 2'b10; Ack_in = 0;

    //            mr s0 s1 ak d0       d1        so a0 a1 dout     g  c  e  b  c0 c1 er
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'hA5A5, 16'h0000, 1, 0, 0, 16'hA5A5, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 16'hA5A5, 16'h0000, 0, 1, 0, 16'hA5A5, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'hA5A5, 16'h0000, 0, 0, 0, 16'hA5A5, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h1111, 16'h2222, 1, 0, 0, 16'h1111, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 16'h1111, 16'h2222, 0, 1, 0, 16'h1111, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h1111, 16'h2222, 0, 0, 0, 16'h1111, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h1111, 16'h2222, 1, 0, 0, 16'h2222, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 16'h1111, 16'h2222, 0, 0, 1, 16'h2222, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h1111, 16'h2222, 0, 0, 0, 16'h2222, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h1111, 16'h2222, 1, 0, 0, 16'h1111, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 16'h1111, 16'h2222, 0, 1, 0, 16'h1111, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h1111, 16'h2222, 0, 0, 0, 16'h1111, 0, 1, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h1111, 16'h2222, 1, 0, 0, 16'h2222, 1, 0, 1, 1, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 16'h1111, 16'h2222, 0, 0, 1, 16'h2222, 1, 0, 1, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h1111, 16'h2222, 0, 0, 0, 16'h2222, 1, 0, 1, 0, 2, 2, 0));

    #1;
    foreach (tbl[i]) begin
      MR = tbl[i].mr; Send_in0 = tbl[i].s0; Send_in1 = tbl[i].s1; Ack_in = tbl[i].ack;
      Data_in0 = tbl[i].d0; Data_in1 = tbl[i].d1;
      step();
      chk($sformatf("v%0d.so", i),   32'(Send_out), 32'(tbl[i].so));
      chk($sformatf("v%0d.a0", i),   32'(Ack_out0), 32'(tbl[i].a0));
      chk($sformatf("v%0d.a1", i),   32'(Ack_out1), 32'(tbl[i].a1));
      chk($sformatf("v%0d.dout", i), 32'(Data_out), 32'(tbl[i].dout));
      chk($sformatf("v%0d.gnt", i),  32'(GNT),      32'(tbl[i].gnt));
      chk($sformatf("v%0d.cpy", i),  32'(CPY),      32'(tbl[i].cpy));
      chk($sformatf("v%0d.exb", i),  32'(EXB),      32'(tbl[i].exb));
      chk($sformatf("v%0d.busy", i), 32'(BUSY),     32'(tbl[i].busy));
      chk($sformatf("v%0d.cnt0", i), 32'(CNT0),     32'(tbl[i].c0));
      chk($sformatf("v%0d.cnt1", i), 32'(CNT1),     32'(tbl[i].c1));
      chk($sformatf("v%0d.err", i),  32'(ERR),      32'(tbl[i].err));
    end

    // Mask: input 0 requesting but disabled must never be granted.
    EN = 2'b10; Send_in0 = 1'b1; Data_in0 = 16'hBEEF;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("mask.no_grant", 32'({Send_out, BUSY}), 0);
    end
    Send_in1 = 1'b1; Data_in1 = 16'h3333;
    step();
    chk("mask.so", 32'(Send_out), 1);
    chk("mask.gnt", 32'(GNT), 1);
    chk("mask.data", 32'(Data_out), 32'h3333);
    Ack_in = 1'b1;
    step();
    Ack_in = 1'b0; Send_in1 = 1'b0;
    step();
    chk("mask.cnt1", 32'(CNT1), 3);
    chk("mask.cnt0", 32'(CNT0), 2);
    Send_in0 = 1'b0; EN = 2'b11;

    // Counter wrap on a 2-bit counter starting from reset.
    MR = 1'b1;
    step();
    MR = 1'b0;
    chk_reset_vals("rst1");
    xfer1(16'h0001, 2'd1);
    xfer1(16'h0002, 2'd2);
    xfer1(16'h0003, 2'd3);
    xfer1(16'h0004, 2'd0);
    xfer1(16'h0005, 2'd1);

    // Timeout: ERR after the 4th REQ cycle, transfer still completes.
    Send_in1 = 1'b1; Data_in1 = 16'h7777;
    step();
    chk("tmo.grant", 32'(Send_out), 1);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("tmo.err_low%0d", c), 32'(ERR), 0);
    end
    step();
    chk("tmo.err_set", 32'(ERR), 1);
    chk("tmo.so_held", 32'(Send_out), 1);
    chk("tmo.data_held", 32'(Data_out), 32'h7777);
    Ack_in = 1'b1;
    step();
    chk("tmo.ack1", 32'(Ack_out1), 1);
    Ack_in = 1'b0; Send_in1 = 1'b0;
    step();
    chk("tmo.done_busy", 32'(BUSY), 0);
    chk("tmo.cnt1", 32'(CNT1), 2);
    chk("tmo.err_sticky", 32'(ERR), 1);
    xfer1(16'h0008, 2'd3);

    // Reset in ACKUP with CNT1=3.
    Send_in1 = 1'b1; Data_in1 = 16'h9999;
    step();
    Ack_in = 1'b1;
    step();
    chk("rst2.in_ackup", 32'(Ack_out1), 1);
    chk("rst2.cnt1_pre", 32'(CNT1), 3);
    MR = 1'b1;
    step();
    chk_reset_vals("rst2");
    MR = 1'b0; Ack_in = 1'b0; Send_in0 = 1'b1; Data_in0 = 16'h4242;
    step();
    chk("rst2.next_so", 32'(Send_out), 1);
    chk("rst2.next_gnt", 32'(GNT), 0);
    chk("rst2.next_data", 32'(Data_out), 32'h4242);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mg2_arbiter.md
# mg2_arbiter

Synchronous two-input merge arbiter for Send/Ack packet channels in the DDP pipeline. It places two requesting streams onto one downstream Send/Ack channel using round-robin priority. It registers the winner's data word and its copy/exchange mode (CPY/EXB) so a downstream CX2 stage is configured per packet. It also keeps per-input transfer counters and a sticky downstream-timeout flag.

## Interface
- W, 16, data word width
- CNTW, 8, transfer counter width
- TMO, 255, REQ-state cycles before ERR is set (1..2^16-1)
- CLK  in  1  clock, all logic on rising edge
- MR  in  1  reset, synchronous, active-high
- Send_in0, Send_in1  in  1  request from input 0 / 1
- Data_in0, Data_in1  in  W  data from input 0 / 1, valid while Send_inN=1
- Ack_out0, Ack_out1  out  1  acknowledge to input 0 / 1
- EN  in  2  requester enable mask; bit N=0 ignores Send_inN in IDLE
- CFG_CPY, CFG_EXB  in  2  per-input mode bits (bit N for input N)
- Send_out  out  1  request to downstream
- Ack_in  in  1  acknowledge from downstream
- Data_out  out  W  granted data, stable while Send_out=1
- CPY, EXB  out  1  granted input's mode bits, stable from grant until return to IDLE
- GNT  out  1  index of the granted input
- BUSY  out  1  state != IDLE
- CNT0, CNT1  out  CNTW  completed transfers per input
- ERR  out  1  sticky timeout flag

## Operation
- Both channels use a 4-phase return-to-zero handshake with active-high levels. All inputs are synchronous to CLK; synchronisers are outside this block.
- Input side sequence: Send_inN rises, Ack_outN rises, Send_inN falls, Ack_outN falls.
- Output side sequence: Send_out rises, Ack_in rises, Send_out falls, Ack_in falls.
- The FSM has three states: IDLE, REQ, ACKUP.
- IDLE
  - An input is eligible when Send_inN & EN[N].
  - If only one input is eligible, grant it.
  - If both are eligible, grant input PRI.
  - On grant: latch GNT, Data_out ← Data_inGNT, CPY ← CFG_CPY[GNT], EXB ← CFG_EXB[GNT]; Send_out←1; go to REQ.
- REQ
  - Hold Send_out=1 and hold all latched outputs.
  - On Ack_in=1: Send_out←0, Ack_out[GNT]←1, go to ACKUP.
  - A watchdog counts the cycles spent in REQ. When the count reaches TMO, ERR←1. The FSM keeps waiting; there is no abort.
- ACKUP
  - Wait until Ack_in=0 and Send_in[GNT]=0, checked in the same cycle.
  - Then: Ack_out[GNT]←0, CNT[GNT]←CNT[GNT]+1 (wraps modulo 2^CNTW), PRI←~GNT, go to IDLE.
- PRI is the round-robin pointer. After each completed transfer, the last-served input gets the lower priority.
- If Send_in[GNT] drops during REQ (protocol violation), the transfer still completes and the drop is ignored.
- Changing EN or CFG_* while BUSY has no effect until the next grant.
- ERR clears only on MR.

## Timing
- Grant latency: Send_inN is sampled high in IDLE at edge t, and Send_out=1 with valid Data_out/CPY/EXB/GNT appears after edge t.
- Ack_in sampled high at edge k gives Send_out=0 and Ack_outN=1 after edge k.
- The release condition met at edge m gives Ack_outN=0, CNT updated and BUSY=0 after edge m.
- New-grant eligibility: the earliest new grant is at edge m+1.
- The minimum transfer takes 3 cycles.
- No output has a combinational path from any input; all outputs are registered.
- A requester that keeps Send_inN=1 after its Ack_outN falls is treated as a new request.
- Reset applies at the first edge with MR=1, in any state, including mid-transfer. The values after that edge are:
  - state=IDLE, PRI=0
  - Send_out, Ack_out0, Ack_out1 = 0
  - Data_out=0, CPY=0, EXB=1, GNT=0
  - BUSY=0, CNT0=CNT1=0, ERR=0, watchdog=0
- MR has priority over all other events.

## Test plan
- Single request:
  - Stimulus: EN=2'b11, Send_in0=1, Data_in0=16'hA5A5, CFG_CPY=2'b01, CFG_EXB=2'b00.
  - Response: one cycle later Send_out=1, Data_out=A5A5, CPY=1, EXB=0, GNT=0.
  - Then Ack_in=1 gives Ack_out0=1 and Send_out=0. Dropping Ack_in and Send_in0 gives CNT0=1 and BUSY=0.
- Simultaneous requests:
  - Stimulus: Send_in0 and Send_in1 held high, downstream acks every packet.
  - Response: grants alternate 0,1,0,1. After 4 transfers CNT0=2 and CNT1=2.
- Mask:
  - Stimulus: EN=2'b10, Send_in0=1.
  - Response: no grant for 20 cycles. Raising Send_in1 then grants GNT=1.
- Timeout:
  - Stimulus: TMO=4, Ack_in held 0 after a grant.
  - Response: ERR=1 after the 4th REQ cycle, Send_out stays 1. A later Ack_in completes the transfer with ERR still 1.
- Reset mid-transfer:
  - Stimulus: assert MR in ACKUP with CNT1=3.
  - Response: every output takes its reset value one edge later, and the next grant with both inputs requesting goes to input 0.
- Counter wrap:
  - Stimulus: CNTW=2, 5 transfers on input 1.
  - Response: CNT1 sequence 1,2,3,0,1.
